// File: rtl/coord_bcd_converter.sv
// Sequential binary-to-BCD converter for the mouse X/Y coordinates.
// Periodically (or on request) converts both coordinates with double-dabble, X then Y.
module coord_bcd_converter #(
    parameter int IN_WIDTH       = 10,   // must be >= 10 so that 999 fits in the operand
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    input  logic        update_req,
    output logic [11:0] x_bcd,
    output logic [11:0] y_bcd,
    output logic        valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        CONV_X,
        CONV_Y,
        COMMIT
    } state_e;

    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(IN_WIDTH - 1);
    localparam logic [IN_WIDTH-1:0] SAT_MAX = IN_WIDTH'(999);

    // Anything above 999, including bits beyond the operand width, clamps to 999.
    function automatic logic [IN_WIDTH-1:0] saturate(input logic [15:0] v);
        if ((v > 16'd999) || ((v >> IN_WIDTH) != 16'd0))
            return SAT_MAX;
        return IN_WIDTH'(v);
    endfunction

    function automatic logic [3:0] fix_nibble(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    state_e                state_q, state_d;
    logic [REF_W-1:0]      ref_q, ref_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IN_WIDTH-1:0]   op_q, op_d;
    logic [IN_WIDTH-1:0]   y_op_q, y_op_d;
    logic [11:0]           acc_q, acc_d;
    logic [11:0]           x_res_q, x_res_d;
    logic [11:0]           x_bcd_q, x_bcd_d;
    logic [11:0]           y_bcd_q, y_bcd_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;

    logic                  tick;
    logic                  start;
    logic [11:0]           acc_adj;
    logic [11:0]           acc_shift;
    logic [IN_WIDTH-1:0]   op_shift;
    logic                  last_bit;

    assign tick     = (ref_q == REF_LAST);
    assign start    = tick | update_req;
    assign ref_d    = tick ? '0 : ref_q + REF_W'(1);
    assign last_bit = (cnt_q == BIT_LAST);

    // One double-dabble step: correct each digit, then shift {acc, op} left by one.
    assign acc_adj   = {fix_nibble(acc_q[11:8]), fix_nibble(acc_q[7:4]), fix_nibble(acc_q[3:0])};
    assign acc_shift = {acc_adj[10:0], op_q[IN_WIDTH-1]};
    assign op_shift  = {op_q[IN_WIDTH-2:0], 1'b0};

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        y_op_d  = y_op_q;
        acc_d   = acc_q;
        x_res_d = x_res_q;
        x_bcd_d = x_bcd_q;
        y_bcd_d = y_bcd_q;

        unique case (state_q)
            IDLE: begin
                if (start)
                    state_d = CAPTURE;
            end
            CAPTURE: begin
                op_d    = saturate(x_in);
                y_op_d  = saturate(y_in);
                acc_d   = '0;
                cnt_d   = '0;
                state_d = CONV_X;
            end
            CONV_X: begin
                acc_d = acc_shift;
                op_d  = op_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    x_res_d = acc_shift;
                    acc_d   = '0;
                    cnt_d   = '0;
                    op_d    = y_op_q;
                    state_d = CONV_Y;
                end
            end
            CONV_Y: begin
                acc_d = acc_shift;
                op_d  = op_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    // Both results land on the same edge so the display never mixes old and new.
                    x_bcd_d = x_res_q;
                    y_bcd_d = acc_shift;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign valid_d = (state_d == COMMIT);
    assign busy_d  = (state_d != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ref_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            y_op_q  <= '0;
            acc_q   <= '0;
            x_res_q <= '0;
            x_bcd_q <= '0;
            y_bcd_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            y_op_q  <= y_op_d;
            acc_q   <= acc_d;
            x_res_q <= x_res_d;
            x_bcd_q <= x_bcd_d;
            y_bcd_q <= y_bcd_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign x_bcd = x_bcd_q;
    assign y_bcd = y_bcd_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule
